obstacle_scheduler: RTL and testbench

Sequences the obstacle generators (horizontal lasers, vertical lasers and the other obstacle blocks) during a round of play. Picks the next obstacle pseudo-randomly without immediate repeats and launches it with a one-cycle `done_control` pulse plus a one-hot `selected` code. It then waits for that obstacle's `done`, inserts a gap, and declares the round won after a configured number of cleared obstacles. It sits between the menu/game-state logic and the obstacle generators' `done_control`/`selected` inputs.

---
 rtl/obstacle_scheduler_if.sv | 22 ++
 rtl/obstacle_scheduler.sv | 159 +++++++++++++++
 tb/tb_obstacle_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_scheduler_if.sv
// Launch bus between the obstacle scheduler
// and the obstacle generators.
interface obstacle_scheduler_if;
  logic [3:0] done_in;
  logic [3:0] working_in;
  logic [3:0] selected;
  logic       done_control;

  modport master (
    input  done_in,
    input  working_in,
    output selected,
    output done_control
  );

  modport slave (
    output done_in,
    output working_in,
    input  selected,
    input  done_control
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Round sequencer: picks obstacles pseudo-randomly,
// launches them, waits for done, declares the win.
module obstacle_scheduler #(
  parameter int unsigned GAP_CYCLES       = 32000000,
  parameter int unsigned TIMEOUT_CYCLES   = 2000000000,
  parameter int unsigned OBSTACLES_TO_WIN = 8,
  parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 game_on,
  input  logic                 menu_on,
  input  logic                 play_selected,
  obstacle_scheduler_if.master obs,
  output logic                 obstacle_active,
  output logic [7:0]           cleared_count,
  output logic                 timeout_err,
  output logic                 game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LAUNCH,
    S_RUN,
    S_WON
  } state_t;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  WIN_CNT  = 8'(OBSTACLES_TO_WIN);

  state_t      r_state, w_state_n;
  logic [7:0]  r_lfsr;
  logic [1:0]  r_last, w_last_n;
  logic [31:0] r_gap, w_gap_n;
  logic [31:0] r_wd, w_wd_n;
  logic [3:0]  r_sel, w_sel_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic        r_dc, r_active, r_terr, r_won;
  logic        w_terr_n;
  logic        w_abort, w_start, w_done, w_fb;
  logic [1:0]  w_idx;
  logic [7:0]  w_cnt_inc;
  logic        w_unused;

  assign w_abort   = menu_on | ~play_selected;
  assign w_start   = game_on & play_selected & ~menu_on;
  assign w_done    = obs.done_in[r_last];
  assign w_fb      = r_lfsr[7] ^ r_lfsr[5]
                   ^ r_lfsr[4] ^ r_lfsr[3];
  // Step off the previous index to avoid repeats.
  assign w_idx     = (r_lfsr[1:0] == r_last)
                   ? r_lfsr[1:0] + 2'd1
                   : r_lfsr[1:0];
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt
                   : r_cnt + 8'd1;
  assign w_unused  = ^obs.working_in;

  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_gap_n   = r_gap;
    w_wd_n    = r_wd;
    w_sel_n   = r_sel;
    w_cnt_n   = r_cnt;
    w_terr_n  = 1'b0;
    if (w_abort && r_state != S_IDLE) begin
      w_state_n = S_IDLE;
      w_sel_n   = 4'd0;
      w_gap_n   = 32'd0;
      w_wd_n    = 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_gap_n = 32'd0;
          w_wd_n  = 32'd0;
          if (w_start) begin
            w_state_n = S_GAP;
            w_cnt_n   = 8'd0;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_state_n = S_LAUNCH;
            w_gap_n   = 32'd0;
            w_sel_n   = 4'b0001 << w_idx;
            w_last_n  = w_idx;
          end else begin
            w_gap_n = r_gap + 32'd1;
          end
        end
        S_LAUNCH: begin
          w_state_n = S_RUN;
          w_wd_n    = 32'd0;
        end
        S_RUN: begin
          // A done beats a coincident watchdog expiry.
          if (w_done) begin
            w_cnt_n   = w_cnt_inc;
            w_sel_n   = 4'd0;
            w_wd_n    = 32'd0;
            w_state_n = (w_cnt_inc == WIN_CNT)
                      ? S_WON : S_GAP;
          end else if (r_wd == WD_LAST) begin
            w_terr_n  = 1'b1;
            w_sel_n   = 4'd0;
            w_wd_n    = 32'd0;
            w_state_n = S_GAP;
          end else begin
            w_wd_n = r_wd + 32'd1;
          end
        end
        S_WON: begin
          w_state_n = S_WON;
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_last   <= 2'd3;
      r_gap    <= 32'd0;
      r_wd     <= 32'd0;
      r_sel    <= 4'd0;
      r_cnt    <= 8'd0;
      r_dc     <= 1'b0;
      r_active <= 1'b0;
      r_terr   <= 1'b0;
      r_won    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_lfsr   <= {r_lfsr[6:0], w_fb};
      r_last   <= w_last_n;
      r_gap    <= w_gap_n;
      r_wd     <= w_wd_n;
      r_sel    <= w_sel_n;
      r_cnt    <= w_cnt_n;
      r_dc     <= (w_state_n == S_LAUNCH);
      r_active <= (w_state_n == S_RUN);
      r_terr   <= w_terr_n;
      r_won    <= (w_state_n == S_WON);
    end
  end

  assign obs.selected     = r_sel;
  assign obs.done_control = r_dc;
  assign obstacle_active  = r_active;
  assign cleared_count    = r_cnt;
  assign timeout_err      = r_terr;
  assign game_won         = r_won;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler:
// launch timing, selection, watchdog, abort, reset.
module tb_obstacle_scheduler;

  localparam int         G    = 4;
  localparam int         TO   = 20;
  localparam int         WIN  = 3;
  localparam logic [7:0] SEED = 8'h1D;

  logic       pclk          = 1'b0;
  logic       rst           = 1'b0;
  logic       game_on       = 1'b0;
  logic       menu_on       = 1'b0;
  logic       play_selected = 1'b0;
  logic       obstacle_active;
  logic [7:0] cleared_count;
  logic       timeout_err;
  logic       game_won;

  obstacle_scheduler_if bus();

  obstacle_scheduler #(
    .GAP_CYCLES      (G),
    .TIMEOUT_CYCLES  (TO),
    .OBSTACLES_TO_WIN(WIN),
    .LFSR_SEED       (SEED)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .game_on        (game_on),
    .menu_on        (menu_on),
    .play_selected  (play_selected),
    .obs            (bus),
    .obstacle_active(obstacle_active),
    .cleared_count  (cleared_count),
    .timeout_err    (timeout_err),
    .game_won       (game_won)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Reference LFSR; m_prev is the value seen at the last edge.
  logic [7:0] m_lfsr = SEED;
  logic [7:0] m_prev = SEED;
  always @(posedge pclk) begin
    m_prev <= m_lfsr;
    m_lfsr <= rst ? {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5]
                     ^ m_lfsr[4] ^ m_lfsr[3]} : SEED;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_q[$];
  logic [1:0] m_last   = 2'd3;
  logic [3:0] prev_sel = 4'b1000;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic chk_idle_outs(input string tag,
                               input logic [7:0] cnt);
    n_cmp++;
    if (bus.selected !== 4'd0) begin
      n_err++;
      $display("FAIL %s selected: got %b want 0000",
               tag, bus.selected);
    end
    n_cmp++;
    if (bus.done_control !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_control: got %b want 0",
               tag, bus.done_control);
    end
    n_cmp++;
    if (obstacle_active !== 1'b0) begin
      n_err++;
      $display("FAIL %s active: got %b want 0",
               tag, obstacle_active);
    end
    n_cmp++;
    if (cleared_count !== cnt) begin
      n_err++;
      $display("FAIL %s count: got %0d want %0d",
               tag, cleared_count, cnt);
    end
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s timeout_err: got %b want 0",
               tag, timeout_err);
    end
    n_cmp++;
    if (game_won !== 1'b0) begin
      n_err++;
      $display("FAIL %s game_won: got %b want 0",
               tag, game_won);
    end
  endtask

  // Pops the expected launch cycle and checks the launch.
  task automatic wait_launch(output logic [3:0] sel,
                             input bit stay);
    int         exp_c;
    bit         found;
    logic [1:0] ei;
    logic [3:0] es;
    sel   = 4'd0;
    found = 1'b0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL launch_queue: got empty want entry");
      return;
    end
    exp_c = exp_q.pop_front();
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (bus.done_control === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_err++;
      $display("FAIL launch_wait: none by %0d want %0d",
               cyc, exp_c);
      return;
    end
    if (cyc != exp_c) begin
      n_err++;
      $display("FAIL launch_cycle: got %0d want %0d",
               cyc, exp_c);
    end
    ei = m_prev[1:0];
    if (ei == m_last) ei = ei + 2'd1;
    es     = 4'b0001 << ei;
    m_last = ei;
    n_cmp++;
    if (bus.selected !== es) begin
      n_err++;
      $display("FAIL launch_sel: got %b want %b",
               bus.selected, es);
    end
    n_cmp++;
    if (!$onehot(bus.selected)
        || bus.selected === prev_sel) begin
      n_err++;
      $display("FAIL launch_repeat: got %b prev %b",
               bus.selected, prev_sel);
    end
    sel      = bus.selected;
    prev_sel = sel;
    if (stay) return;
    tick();
    n_cmp++;
    if (bus.done_control !== 1'b0
        || obstacle_active !== 1'b1
        || bus.selected !== sel) begin
      n_err++;
      $display("FAIL run_entry: got dc=%b act=%b sel=%b want 0 1 %b",
               bus.done_control, obstacle_active,
               bus.selected, sel);
    end
  endtask

  task automatic abort_round();
    menu_on = 1'b1;
    game_on = 1'b0;
    tick();
    menu_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic no_launch_for(input string tag,
                               input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done_control !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL %s: got done_control pulse want none",
               tag);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    bus.done_in    = 4'd0;
    bus.working_in = 4'd0;
    repeat (3) tick();
    chk_idle_outs("reset", 8'd0);
    rst      = 1'b1;
    m_last   = 2'd3;
    prev_sel = 4'b1000;
    exp_q.delete();
    no_launch_for("reset_idle", 8);
  endtask

  task automatic test_nominal();
    logic [3:0] s;
    game_on       = 1'b1;
    play_selected = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    for (int k = 1; k <= WIN; k++) begin
      wait_launch(s, 1'b0);
      repeat (9) tick();
      bus.done_in    = s;
      bus.working_in = 4'hF;
      if (k < WIN) exp_q.push_back(cyc + 1 + G);
      tick();
      bus.done_in = 4'd0;
      n_cmp++;
      if (cleared_count !== 8'(k)
          || bus.selected !== 4'd0) begin
        n_err++;
        $display("FAIL nominal_done: got cnt=%0d sel=%b want %0d 0000",
                 cleared_count, bus.selected, k);
      end
    end
    n_cmp++;
    if (game_won !== 1'b1 || obstacle_active !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_won: got won=%b act=%b want 1 0",
               game_won, obstacle_active);
    end
    no_launch_for("won_quiet", 6);
    n_cmp++;
    if (game_won !== 1'b1) begin
      n_err++;
      $display("FAIL won_level: got %b want 1", game_won);
    end
    abort_round();
    chk_idle_outs("abort_won", 8'(WIN));
  endtask

  task automatic test_wrong_done();
    logic [3:0] s;
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b0);
    tick();
    bus.done_in    = ~s;
    bus.working_in = ~s;
    tick();
    bus.done_in = 4'd0;
    n_cmp++;
    if (obstacle_active !== 1'b1 || cleared_count !== 8'd0
        || bus.selected !== s) begin
      n_err++;
      $display("FAIL wrong_done: got act=%b cnt=%0d sel=%b want 1 0 %b",
               obstacle_active, cleared_count,
               bus.selected, s);
    end
    bus.done_in = s;
    tick();
    bus.done_in = 4'd0;
    n_cmp++;
    if (cleared_count !== 8'd1 || bus.selected !== 4'd0) begin
      n_err++;
      $display("FAIL right_done: got cnt=%0d sel=%b want 1 0000",
               cleared_count, bus.selected);
    end
    tick();
    abort_round();
    chk_idle_outs("abort_gap", 8'd1);
    no_launch_for("abort_gap_quiet", G + 4);
  endtask

  task automatic test_watchdog();
    logic [3:0] s;
    int         n_act;
    bit         seen;
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b0);
    n_act = 1;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (timeout_err === 1'b1) seen = 1'b1;
      else if (obstacle_active === 1'b1) n_act++;
    end
    n_cmp++;
    if (!seen || n_act != TO) begin
      n_err++;
      $display("FAIL watchdog: got seen=%b run=%0d want 1 %0d",
               seen, n_act, TO);
    end
    n_cmp++;
    if (bus.selected !== 4'd0 || cleared_count !== 8'd0) begin
      n_err++;
      $display("FAIL watchdog_outs: got sel=%b cnt=%0d want 0000 0",
               bus.selected, cleared_count);
    end
    exp_q.push_back(cyc + G);
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL watchdog_pulse: got %b want 0",
               timeout_err);
    end
    wait_launch(s, 1'b0);
    repeat (TO - 1) tick();
    bus.done_in = s;
    tick();
    bus.done_in = 4'd0;
    n_cmp++;
    if (timeout_err !== 1'b0 || cleared_count !== 8'd1
        || bus.selected !== 4'd0) begin
      n_err++;
      $display("FAIL coincident: got terr=%b cnt=%0d sel=%b want 0 1 0000",
               timeout_err, cleared_count, bus.selected);
    end
    abort_round();
  endtask

  task automatic test_no_repeat();
    logic [3:0] s;
    bit         seen;
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    for (int i = 0; i < 200; i++) begin
      wait_launch(s, 1'b0);
      seen = 1'b0;
      for (int j = 0; j < 40 && !seen; j++) begin
        tick();
        if (timeout_err === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
        n_err++;
        $display("FAIL repeat_timeout: got none want pulse");
        break;
      end
      exp_q.push_back(cyc + G);
    end
    abort_round();
  endtask

  task automatic test_abort();
    logic [3:0] s;
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b0);
    abort_round();
    chk_idle_outs("abort_run", 8'd0);
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b1);
    play_selected = 1'b0;
    tick();
    game_on       = 1'b0;
    play_selected = 1'b1;
    exp_q.delete();
    chk_idle_outs("abort_launch", 8'd0);
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b0);
    repeat (9) tick();
    bus.done_in = s;
    exp_q.push_back(cyc + 1 + G);
    tick();
    bus.done_in = 4'd0;
    wait_launch(s, 1'b0);
    rst     = 1'b0;
    game_on = 1'b0;
    tick();
    chk_idle_outs("reset_run", 8'd0);
    rst      = 1'b1;
    m_last   = 2'd3;
    prev_sel = 4'b1000;
    exp_q.delete();
    no_launch_for("reset_release", 12);
    game_on = 1'b1;
    exp_q.push_back(cyc + 1 + G);
    wait_launch(s, 1'b0);
    abort_round();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim stalled at cycle %0d",
             cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_wrong_done();
    test_watchdog();
    test_no_repeat();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
